// File: rtl/data_mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: funct3 size codes, FSM state
// codes, default widths and the request legality check.
package data_mem_access_unit_pkg;

    localparam int ADDR_SIZE = 32;
    localparam int WORD_LEN  = 32;
    localparam int DMAU_TIMEOUT_DEFAULT = 256;

    localparam logic [2:0] MEM_SIZE_B  = 3'b000;
    localparam logic [2:0] MEM_SIZE_H  = 3'b001;
    localparam logic [2:0] MEM_SIZE_W  = 3'b010;
    localparam logic [2:0] MEM_SIZE_BU = 3'b100;
    localparam logic [2:0] MEM_SIZE_HU = 3'b101;

    typedef enum logic [1:0] {
        DMAU_IDLE = 2'd0,
        DMAU_BUS  = 2'd1,
        DMAU_DONE = 2'd2
    } dmau_state_e;

    // Legal size and naturally aligned for that size.
    function automatic logic dmau_req_ok(input logic [2:0] size, input logic [1:0] off);
        case (size)
            MEM_SIZE_B, MEM_SIZE_BU: return 1'b1;
            MEM_SIZE_H, MEM_SIZE_HU: return ~off[0];
            MEM_SIZE_W:              return off == 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Multi-cycle data-memory bus (valid/ack). The unit is the master, memory the slave.
interface data_mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                    input  bus_ack, bus_rdata);
    modport slave  (input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                    output bus_ack, bus_rdata);
endinterface

// File: rtl/data_mem_access_unit_lane_align.sv
// Byte-lane alignment: size+offset -> byte enables, store-data replication and
// sign/zero-extended load extract.
module dmau_lane_align
    import data_mem_access_unit_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);
    logic [31:0] lane;

    always_comb begin
        lane      = rdata_in >> {off, 3'b000};
        be        = 4'b1111;
        wdata_out = wdata_in;
        rdata_out = lane;
        case (size)
            MEM_SIZE_B: begin
                be        = 4'b0001 << off;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {{24{lane[7]}}, lane[7:0]};
            end
            MEM_SIZE_BU: begin
                be        = 4'b0001 << off;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {24'h0, lane[7:0]};
            end
            MEM_SIZE_H: begin
                be        = 4'b0011 << off;
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {{16{lane[15]}}, lane[15:0]};
            end
            MEM_SIZE_HU: begin
                be        = 4'b0011 << off;
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {16'h0, lane[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/data_mem_access_unit.sv
// Load/store unit between the MEM stage and a multi-cycle valid/ack data bus.
// Optional bus-wait abort is enabled by defining DMAU_TIMEOUT_EN.
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_SIZE,
    parameter int DATA_W = WORD_LEN
`ifdef DMAU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DMAU_TIMEOUT_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              fault,
    data_mem_access_unit_if.master bus
);
    dmau_state_e       state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              bad_q, bad_d;
    logic              bad_load_q, bad_load_d;
    logic              req_ok, in_bus, timeout_hit, fault_to;
    logic [3:0]        al_be;
    logic [DATA_W-1:0] al_wdata, al_rdata;

    assign req_ok = dmau_req_ok(req_size, req_addr[1:0]);
    assign in_bus = state_q == DMAU_BUS;

    dmau_lane_align u_align (
        .size      (size_q),
        .off       (addr_q[1:0]),
        .wdata_in  (wdata_q),
        .rdata_in  (bus.bus_rdata),
        .be        (al_be),
        .wdata_out (al_wdata),
        .rdata_out (al_rdata)
    );

`ifdef DMAU_TIMEOUT_EN
    logic [8:0] cnt_q, cnt_d;
    logic       to_q, to_d;

    always_comb begin
        cnt_d       = cnt_q;
        to_d        = to_q;
        timeout_hit = 1'b0;
        if (state_q == DMAU_IDLE) begin
            cnt_d = '0;
            to_d  = 1'b0;
        end else if (in_bus && !bus.bus_ack) begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_d == 9'(TIMEOUT_CYCLES)) begin
                timeout_hit = 1'b1;
                to_d        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign fault_to = (state_q == DMAU_DONE) && to_q;
`else
    assign timeout_hit = 1'b0;
    assign fault_to    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= DMAU_IDLE;
        else     state_q <= state_d;
    end

    // A request seen in DONE is the instruction just served, so only IDLE accepts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DMAU_IDLE: if (req_valid && req_ok) state_d = DMAU_BUS;
            DMAU_BUS:  if (bus.bus_ack || timeout_hit) state_d = DMAU_DONE;
            DMAU_DONE: state_d = DMAU_IDLE;
            default:   state_d = DMAU_IDLE;
        endcase
    end

    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        bad_d      = 1'b0;
        bad_load_d = 1'b0;
        if (state_q == DMAU_IDLE && req_valid) begin
            if (req_ok) begin
                we_d    = req_write;
                addr_d  = req_addr;
                size_d  = req_size;
                wdata_d = req_wdata;
            end else begin
                bad_d      = 1'b1;
                bad_load_d = ~req_write;
                rdata_d    = '0;
            end
        end
        if (in_bus && bus.bus_ack) rdata_d = al_rdata;
        if (timeout_hit)           rdata_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            bad_q      <= 1'b0;
            bad_load_q <= 1'b0;
        end else begin
            we_q       <= we_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            bad_q      <= bad_d;
            bad_load_q <= bad_load_d;
        end
    end

    // Bus outputs are quiet outside BUS so reset and idle both read as all-zero.
    always_comb begin
        stall         = ~rst & ((state_q == DMAU_IDLE && req_valid && req_ok) || in_bus);
        bus.bus_req   = in_bus;
        bus.bus_we    = in_bus & we_q;
        bus.bus_addr  = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        bus.bus_be    = in_bus ? (we_q ? al_be : 4'b1111) : 4'b0000;
        bus.bus_wdata = (in_bus && we_q) ? al_wdata : '0;
        rdata_valid   = ((state_q == DMAU_DONE) && !we_q) || bad_load_q;
        fault         = bad_q | fault_to;
        rdata         = rdata_q;
    end
endmodule
